onchip_mem_frame_reader: RTL and testbench

- Downstream consumer of the 24000 x 32-bit single-port on-chip frame memory in the PCIe display Qsys system.
- Acts as the memory's only reader: sweeps word addresses BASE_WORD..BASE_WORD+FRAME_WORDS-1 repeatedly.
- Buffers read data in a small FIFO and presents it as an Avalon-ST source with sop/eop per frame, for the display output pipeline.
- Stops only on frame boundaries.

---
 rtl/onchip_mem_frame_reader.sv | 154 +++++++++++++++
 tb/tb_onchip_mem_frame_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_frame_reader.sv
`default_nettype none
// ============================================================================
// onchip_mem_frame_reader : sweeps the on-chip frame memory and streams each
//                           frame as Avalon-ST with sop/eop through a FIFO
// Revision: 1.0  initial release
// ============================================================================
module onchip_mem_frame_reader #(
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 32,
   parameter int FRAME_WORDS = 24000,
   parameter int BASE_WORD   = 0,
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_clken,
   output logic                mem_write,
   output logic [DATA_W/8-1:0] mem_byteenable,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [DATA_W-1:0]   src_data,
   output logic                src_valid,
   input  logic                src_ready,
   output logic                src_sop,
   output logic                src_eop,
   output logic                busy,
   output logic [CNT_W-1:0]    frame_count
);

   localparam int                PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_WORD);
   localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(FRAME_WORDS - 1);
   localparam logic [PTR_W:0]    c_full     = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t r_state, w_state_next;

   logic [ADDR_W-1:0]   r_index;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_inflight;
   logic                r_infl_sop;
   logic                r_infl_eop;
   logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifo_sop;
   logic [FIFO_DEPTH-1:0] r_fifo_eop;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W:0]      r_count;
   logic [CNT_W-1:0]    r_frame_count;

   logic                w_issue;
   logic                w_last;
   logic                w_push;
   logic                w_pop;
   logic [PTR_W:0]      w_credit;

   // Words already buffered plus the word on its way back never exceed the
   // FIFO depth, so this sum always fits in PTR_W+1 bits.
   assign w_credit = r_count + {{PTR_W{1'b0}}, r_inflight};
   assign w_issue  = (r_state == S_FETCH) && (w_credit < c_full);
   assign w_last   = (r_index == c_last_idx);
   assign w_push   = r_inflight;
   assign w_pop    = src_valid && src_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (enable) w_state_next = S_FETCH;
         S_FETCH: if (w_issue && w_last && !enable) w_state_next = S_DRAIN;
         S_DRAIN: if (!r_inflight && (r_count == '0)) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Read issue: index wraps back-to-back on the last word of a frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_index    <= '0;
         r_addr     <= c_base;
         r_inflight <= 1'b0;
         r_infl_sop <= 1'b0;
         r_infl_eop <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_infl_sop <= (r_index == '0);
            r_infl_eop <= w_last;
            r_addr     <= c_base + r_index;
            r_index    <= w_last ? '0 : r_index + ADDR_W'(1);
         end else if (r_state == S_IDLE) begin
            r_index <= '0;
            r_addr  <= c_base;
         end
      end
   end

   assign mem_address    = w_issue ? (c_base + r_index) : r_addr;
   assign mem_chipselect = w_issue;
   assign mem_clken      = 1'b1;
   assign mem_write      = 1'b0;
   assign mem_byteenable = '1;

   // FIFO storage needs no reset; only pointers and count define occupancy
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= mem_readdata;
         r_fifo_sop[r_wr_ptr]  <= r_infl_sop;
         r_fifo_eop[r_wr_ptr]  <= r_infl_eop;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_frame_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop && src_eop) r_frame_count <= r_frame_count + CNT_W'(1);
      end
   end

   assign src_valid   = (r_count != '0);
   assign src_data    = r_fifo_data[r_rd_ptr];
   assign src_sop     = src_valid && r_fifo_sop[r_rd_ptr];
   assign src_eop     = src_valid && r_fifo_eop[r_rd_ptr];
   assign busy        = (r_state != S_IDLE) || (r_count != '0);
   assign frame_count = r_frame_count;

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(w_push && !w_pop && (r_count == c_full)));

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_frame_reader.sv
`default_nettype none
// ============================================================================
// tb_onchip_mem_frame_reader : randomized bench with a frame-level stream model
// Revision: 1.0  initial release
// ============================================================================
module tb_onchip_mem_frame_reader;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int F      = 16;
   localparam int BASE   = 200;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                enable;
   logic [ADDR_W-1:0]   mem_address;
   logic                mem_chipselect;
   logic                mem_clken;
   logic                mem_write;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic [DATA_W-1:0]   mem_readdata;
   logic [DATA_W-1:0]   src_data;
   logic                src_valid;
   logic                src_ready;
   logic                src_sop;
   logic                src_eop;
   logic                busy;
   logic [CNT_W-1:0]    frame_count;

   logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

   int n_vec = 0;
   int n_bad = 0;

   // Stream model: position in frame, frames/beats delivered, words requested
   int k, frames, issues, pops, beats, cyc, first_cyc, last_cyc, phase_beats0, rdy_mode;
   logic              prev_stall;
   logic [DATA_W-1:0] prev_data;
   logic              prev_sop, prev_eop;

   onchip_mem_frame_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(F), .BASE_WORD(BASE),
      .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect),
      .mem_clken(mem_clken), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .src_sop(src_sop), .src_eop(src_eop), .busy(busy), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_chipselect) mem_readdata <= mem[mem_address];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Sampled mid-cycle, with src_ready already set for the coming edge
   task automatic monitor();
      if (mem_chipselect) begin
         chk("issue_addr", 64'(mem_address), 64'(BASE + (issues % F)));
         chk("credit", 64'((issues - pops) < DEPTH), 64'(1));
         issues++;
      end
      if (prev_stall) begin
         chk("hold_valid", 64'(src_valid), 64'(1));
         chk("hold_data", 64'(src_data), 64'(prev_data));
         chk("hold_tags", 64'({src_sop, src_eop}), 64'({prev_sop, prev_eop}));
      end
      if (src_valid && src_ready) begin
         chk("data", 64'(src_data), 64'(mem[BASE + k]));
         chk("sop", 64'(src_sop), 64'(k == 0));
         chk("eop", 64'(src_eop), 64'(k == F - 1));
         chk("frame_count_beat", 64'(frame_count), 64'(frames));
         if (beats == phase_beats0) first_cyc = cyc;
         last_cyc = cyc;
         beats++;
         pops++;
         if (k == F - 1) begin
            frames++;
            k = 0;
         end else begin
            k++;
         end
      end
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      prev_sop   = src_sop;
      prev_eop   = src_eop;
   endtask

   task automatic cycle();
      @(negedge clk);
      case (rdy_mode)
         0:       src_ready = 1'b1;
         1:       src_ready = ($urandom_range(99) < 30);
         2:       src_ready = ((cyc % 7) < 3);
         default: src_ready = ($urandom_range(99) < 60);
      endcase
      #1;
      if (reset_n) monitor();
      cyc++;
   endtask

   task automatic wait_beats(input int n, input int max_cyc);
      for (int i = 0; i < max_cyc && beats < n; i++) cycle();
      chk("beats_timeout", 64'(beats >= n), 64'(1));
   endtask

   task automatic wait_idle(input int max_cyc);
      cycle();
      for (int i = 0; i < max_cyc && busy; i++) cycle();
      chk("idle_timeout", 64'(busy), 64'(0));
   endtask

   // pulse=1: enable for one cycle (one frame); else hold it until frame 3 is under way
   task automatic run_phase(input int pulse, input int mode, input int exp_frames);
      int f0, b0;
      rdy_mode     = mode;
      f0           = frames;
      b0           = beats;
      phase_beats0 = beats;
      cycle();
      enable = 1'b1;
      if (pulse != 0) begin
         cycle();
         enable = 1'b0;
      end else begin
         wait_beats(b0 + 2 * F + 3, 3000);
         enable = 1'b0;
      end
      wait_idle(3000);
      chk("frames", 64'(frames - f0), 64'(exp_frames));
      chk("beats", 64'(beats - b0), 64'(exp_frames * F));
      chk("frame_count", 64'(frame_count), 64'(frames));
      chk("boundary", 64'(k), 64'(0));
      chk("issued_eq_popped", 64'(issues), 64'(pops));
      if (mode == 0) chk("contiguous", 64'(last_cyc - first_cyc), 64'(exp_frames * F - 1));
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid", 64'(src_valid), 64'(0));
      chk("rst_sop", 64'(src_sop), 64'(0));
      chk("rst_eop", 64'(src_eop), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_frame_count", 64'(frame_count), 64'(0));
      chk("rst_cs", 64'(mem_chipselect), 64'(0));
      chk("rst_addr", 64'(mem_address), 64'(BASE));
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; src_ready = 1'b0; rdy_mode = 0;
      k = 0; frames = 0; issues = 0; pops = 0; beats = 0; cyc = 0;
      first_cyc = 0; last_cyc = 0; phase_beats0 = 0;
      prev_stall = 1'b0; prev_data = '0; prev_sop = 1'b0; prev_eop = 1'b0;
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = $urandom;

      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs();
      chk("tie_clken", 64'(mem_clken), 64'(1));
      chk("tie_write", 64'(mem_write), 64'(0));
      chk("tie_byteen", 64'(mem_byteenable), 64'(4'hF));
      @(negedge clk);
      reset_n = 1'b1;

      run_phase(1, 0, 1);   // single frame, full rate
      run_phase(0, 0, 3);   // continuous, drop during frame 3
      run_phase(0, 1, 3);   // 30% ready backpressure
      run_phase(0, 2, 3);   // periodic ready: push/pop at full and empty

      // asynchronous reset in the middle of a frame
      rdy_mode = 3;
      cycle();
      enable = 1'b1;
      wait_beats(beats + 5, 500);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      k = 0; frames = 0; issues = 0; pops = 0; beats = 0; prev_stall = 1'b0;
      enable = 1'b0;
      repeat (3) cycle();
      reset_n = 1'b1;
      run_phase(1, 3, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
